mio_arbiter: RTL and testbench

MIO_ARBITER -- requirements
Module: mio_arbiter

---
 rtl/mio_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mio_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_arbiter.sv
// mio_arbiter
// Two-port round-robin arbiter in front of a single memory port with wait
// states and a bounded wait. Port 0 is the CPU, port 1 is debug/DMA.
// Each transaction walks IDLE -> ACCESS -> DONE, so at most one completes
// every three cycles.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   req0/req1              access requests
//   we0/we1                1 = write, 0 = read, sampled with req
//   addr0/addr1            byte address per port
//   wdata0/wdata1          write data per port
//   gnt                    one-hot grant, held through ACCESS and DONE
//   ack                    one-cycle completion pulse per port
//   err                    1 = last completion was a timeout (held)
//   rdata                  read data from the last successful read (held)
//   mem_req/mem_w          memory strobe and write enable
//   mem_addr/mem_wdata     latched address and write data
//   mem_rdata/mem_ready    memory read data and completion
//   state                  IDLE=0, ACCESS=1, DONE=2
module mio_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_w,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_gnt;
  logic [1:0]  r_ack;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_memReq;
  logic        r_memW;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic [7:0]  r_cnt;
  logic        r_lastGrant;

  logic        w_anyReq;
  logic        w_pick;

  // Winner selection: on a tie the port that did not win last time goes
  // next; a lone requester always wins. w_pick is the winning port index.
  always_comb begin
    w_anyReq = req0 | req1;
    if (req0 && req1) begin
      w_pick = ~r_lastGrant;
    end else begin
      w_pick = req1;
    end
  end

  // Main FSM. All outputs are registered. The grant register doubles as the
  // one-hot winner, so ack is loaded straight from it on completion and the
  // last-grant index is its bit 1. The wait counter compares before it
  // increments, so TIMEOUT=N gives N+1 ACCESS cycles before aborting, and
  // mem_ready is tested first so it wins over a same-cycle timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= 2'b00;
      r_ack       <= 2'b00;
      r_err       <= 1'b0;
      r_rdata     <= 32'd0;
      r_memReq    <= 1'b0;
      r_memW      <= 1'b0;
      r_memAddr   <= 32'd0;
      r_memWdata  <= 32'd0;
      r_cnt       <= 8'd0;
      r_lastGrant <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 2'b00;
          if (w_anyReq) begin
            r_state    <= ACCESS;
            r_gnt      <= w_pick ? 2'b10 : 2'b01;
            r_memReq   <= 1'b1;
            r_memW     <= w_pick ? we1 : we0;
            r_memAddr  <= w_pick ? addr1 : addr0;
            r_memWdata <= w_pick ? wdata1 : wdata0;
            r_cnt      <= 8'd0;
          end else begin
            r_gnt    <= 2'b00;
            r_memReq <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            r_state  <= DONE;
            r_memReq <= 1'b0;
            r_memW   <= 1'b0;
            r_ack    <= r_gnt;
            r_err    <= 1'b0;
            if (!r_memW) begin
              r_rdata <= mem_rdata;
            end
          end else if (r_cnt == TIMEOUT) begin
            r_state  <= DONE;
            r_memReq <= 1'b0;
            r_memW   <= 1'b0;
            r_ack    <= r_gnt;
            r_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_ack       <= 2'b00;
          r_gnt       <= 2'b00;
          r_lastGrant <= r_gnt[1];
        end
        default: begin
          r_state  <= IDLE;
          r_ack    <= 2'b00;
          r_gnt    <= 2'b00;
          r_memReq <= 1'b0;
          r_memW   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign ack       = r_ack;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_req   = r_memReq;
  assign mem_w     = r_memW;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign state     = r_state;

endmodule

// File: tb/tb_mio_arbiter.sv
// tb_mio_arbiter
// Scenario tasks drive the arbiter and check bus-side behaviour inline;
// each expected completion (ack, err, rdata) is queued when its request is
// driven and compared by the completion monitor when ack pulses.
module tb_mio_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, ack;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req, mem_w;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [1:0]  state;

  typedef struct packed {
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbQ[$];
  int   errors = 0;
  int   checks = 0;

  mio_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_w(mem_w), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completion monitor: every ack pulse must match the oldest queued
  // expectation; an ack with nothing queued (or a two-cycle ack) fails.
  always @(negedge clk) begin
    if (!rst && ack !== 2'b00) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_ack: ack=%b with no pending request", ack);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        if (ack !== e.ack || err !== e.err || rdata !== e.rdata) begin
          errors++;
          $display("[TB] FAIL completion: got ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h",
                   ack, err, rdata, e.ack, e.err, e.rdata);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step; step;
    rst = 1'b0;
    checks++;
    if (state !== 2'd0 || gnt !== 2'b00 || ack !== 2'b00 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: state=%0d gnt=%b ack=%b err=%b, want 0 00 00 0", state, gnt, ack, err);
    end
    checks++;
    if (rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h, want 0", rdata, mem_addr, mem_wdata);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_w !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mem: mem_req=%b mem_w=%b, want 0 0", mem_req, mem_w);
    end
    step;
    checks++;
    if (state !== 2'd0 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_req: state=%0d mem_req=%b, want 0 0", state, mem_req);
    end
  endtask

  task automatic test_single_read;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    mem_rdata = 32'hDEADBEEF; mem_ready = 1'b1;
    sbQ.push_back('{ack: 2'b01, err: 1'b0, rdata: 32'hDEADBEEF});
    step;
    req0 = 1'b0;
    checks++;
    if (state !== 2'd1 || mem_req !== 1'b1 || gnt !== 2'b01 || mem_addr !== 32'h10 || mem_w !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_access: state=%0d mem_req=%b gnt=%b addr=%h w=%b, want 1 1 01 10 0",
               state, mem_req, gnt, mem_addr, mem_w);
    end
    step;
    checks++;
    if (state !== 2'd2 || mem_req !== 1'b0 || ack !== 2'b01 || gnt !== 2'b01) begin
      errors++;
      $display("[TB] FAIL read_done: state=%0d mem_req=%b ack=%b gnt=%b, want 2 0 01 01", state, mem_req, ack, gnt);
    end
    mem_ready = 1'b0;
    step;
    checks++;
    if (state !== 2'd0 || ack !== 2'b00 || gnt !== 2'b00 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL read_idle: state=%0d ack=%b gnt=%b rdata=%h, want 0 00 00 deadbeef", state, ack, gnt, rdata);
    end
  endtask

  task automatic test_wait_states;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h55;
    mem_ready = 1'b0; mem_rdata = 32'h0BAD0BAD;
    sbQ.push_back('{ack: 2'b10, err: 1'b0, rdata: 32'hDEADBEEF});
    step;
    req1 = 1'b0; addr1 = 32'hFFFF_0000; wdata1 = 32'h99;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      checks++;
      if (state !== 2'd1 || mem_req !== 1'b1 || mem_w !== 1'b1 || mem_addr !== 32'h20
          || mem_wdata !== 32'h55 || gnt !== 2'b10) begin
        errors++;
        $display("[TB] FAIL wait_access[%0d]: state=%0d req=%b w=%b addr=%h wdata=%h gnt=%b, want 1 1 1 20 55 10",
                 i, state, mem_req, mem_w, mem_addr, mem_wdata, gnt);
      end
      step;
    end
    mem_ready = 1'b0;
    checks++;
    if (state !== 2'd2 || ack !== 2'b10 || gnt !== 2'b10) begin
      errors++;
      $display("[TB] FAIL wait_done: state=%0d ack=%b gnt=%b, want 2 10 10", state, ack, gnt);
    end
    step;
    checks++;
    if (rdata !== 32'hDEADBEEF || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL write_rdata: rdata=%h state=%0d, want deadbeef 0", rdata, state);
    end
  endtask

  task automatic test_timeout;
    int n;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h44;
    mem_ready = 1'b0;
    sbQ.push_back('{ack: 2'b01, err: 1'b1, rdata: 32'hDEADBEEF});
    step;
    req0 = 1'b0; addr0 = 32'h88;
    n = 0;
    while (state === 2'd1 && n < 20) begin
      n++;
      checks++;
      if (mem_addr !== 32'h44) begin
        errors++;
        $display("[TB] FAIL addr_stable: mem_addr=%h, want 44", mem_addr);
      end
      step;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("[TB] FAIL timeout_len: access cycles=%0d, want 5", n);
    end
    checks++;
    if (state !== 2'd2 || ack !== 2'b01 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_done: state=%0d ack=%b err=%b, want 2 01 1", state, ack, err);
    end
    step;
    checks++;
    if (state !== 2'd0 || err !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL timeout_hold: state=%0d err=%b rdata=%h, want 0 1 deadbeef", state, err, rdata);
    end
  endtask

  task automatic test_reset_mid;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    mem_ready = 1'b0; mem_rdata = 32'h11111111;
    step;
    req0 = 1'b0;
    step;
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("[TB] FAIL mid_access: state=%0d, want 1", state);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if (state !== 2'd0 || mem_req !== 1'b0 || ack !== 2'b00 || gnt !== 2'b00 || rdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: state=%0d mem_req=%b ack=%b gnt=%b rdata=%h, want 0 0 00 00 0",
               state, mem_req, ack, gnt, rdata);
    end
    step;
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h200;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
    sbQ.push_back('{ack: 2'b01, err: 1'b0, rdata: 32'hCAFE0001});
    step;
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (gnt !== 2'b01 || mem_addr !== 32'h100) begin
      errors++;
      $display("[TB] FAIL tie_after_reset: gnt=%b addr=%h, want 01 100", gnt, mem_addr);
    end
    step;
    step;
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  expGnt;
    logic [31:0] data;
    expGnt = 2'b10;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'hA0; addr1 = 32'hB0;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data = 32'h5000_0000 + 32'(k);
      mem_rdata = data;
      checks++;
      if (state !== 2'd0) begin
        errors++;
        $display("[TB] FAIL b2b_idle[%0d]: state=%0d, want 0", k, state);
      end
      sbQ.push_back('{ack: expGnt, err: 1'b0, rdata: data});
      step;
      checks++;
      if (gnt !== expGnt || mem_req !== 1'b1 || mem_addr !== (expGnt[1] ? 32'hB0 : 32'hA0)) begin
        errors++;
        $display("[TB] FAIL b2b_grant[%0d]: gnt=%b mem_req=%b addr=%h, want %b 1", k, gnt, mem_req, mem_addr, expGnt);
      end
      step;
      step;
      expGnt = {expGnt[0], expGnt[1]};
    end
    req0 = 1'b0; req1 = 1'b0;
    mem_ready = 1'b0;
    step;
    step;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    mem_rdata = 32'd0; mem_ready = 1'b0;

    test_reset;
    test_single_read;
    test_wait_states;
    test_timeout;
    test_reset_mid;
    test_back_to_back;

    step;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_ack: %0d completions still pending, want 0", sbQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
